// File: rtl/grant_lock_pkg.sv
// Shared types and default sizing for the grant_lock arbiter.
package grant_lock_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } gl_state_t;

   localparam int unsigned GL_N_DEFAULT        = 8;
   localparam int unsigned GL_MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/grant_lock_priority_pick.sv
// Fixed-priority picker: lowest set index wins; all-zero input gives all-zero output.
module priority_pick #(
   parameter int unsigned N = 8
) (
   input  logic [0:N-1]         i_vec,
   output logic [0:N-1]         o_onehot,
   output logic [$clog2(N)-1:0] o_idx
);

   localparam int unsigned IW = $clog2(N);

   logic w_found;

   // scan from index 0 upward and keep the first set bit
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_found  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (i_vec[i] && !w_found) begin
            o_onehot[i] = 1'b1;
            o_idx       = IW'(i);
            w_found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/grant_lock.sv
// Locking priority arbiter: a grant is held until released or until MAX_HOLD
// cycles elapse, after which the timed-out owner is masked for one arbitration.
module grant_lock
   import grant_lock_pkg::*;
#(
   parameter int unsigned N        = GL_N_DEFAULT,
   parameter int unsigned MAX_HOLD = GL_MAX_HOLD_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [0:N-1]         r,
   output logic [0:N-1]         g,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 expired
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned HW = $clog2(MAX_HOLD);

   gl_state_t       r_state;
   logic [HW-1:0]   r_hold;
   logic [0:N-1]    r_mask;

   logic [0:N-1]    w_unmasked;
   logic [0:N-1]    w_cand;
   logic [0:N-1]    w_pick_oh;
   logic [IW-1:0]   w_pick_idx;

   // masked requesters are skipped unless nobody else is asking
   always_comb begin
      w_unmasked = r & ~r_mask;
      w_cand     = (|w_unmasked) ? w_unmasked : r;
   end

   priority_pick #(
      .N(N)
   ) u_pick (
      .i_vec    (w_cand),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx)
   );

   // arbitration state machine with hold counter, mask and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_mask  <= '0;
         g       <= '0;
         owner   <= '0;
         busy    <= 1'b0;
         expired <= 1'b0;
      end else begin
         expired <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|w_cand) begin
                  r_state <= OWN;
                  g       <= w_pick_oh;
                  owner   <= w_pick_idx;
                  busy    <= 1'b1;
                  r_hold  <= '0;
                  r_mask  <= '0;
               end
            end
            OWN: begin
               // release is tested first so it beats a simultaneous timeout
               if (!r[owner]) begin
                  r_state <= IDLE;
                  g       <= '0;
                  busy    <= 1'b0;
               end else if (r_hold == HW'(MAX_HOLD - 1)) begin
                  r_state <= GAP;
                  r_mask  <= g;   // g is the one-hot of owner while in OWN
                  g       <= '0;
                  busy    <= 1'b0;
                  expired <= 1'b1;
               end else begin
                  r_hold  <= r_hold + HW'(1);
               end
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               g       <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grant_lock.sv
// Self-checking bench for grant_lock (N=8, MAX_HOLD=4): directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_grant_lock;

   localparam int N  = 8;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [0:N-1] r;
   logic [0:N-1] g;
   logic [2:0]   owner;
   logic         busy;
   logic         expired;

   always #5 clk = ~clk;

   grant_lock #(
      .N(N),
      .MAX_HOLD(MH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .r       (r),
      .g       (g),
      .owner   (owner),
      .busy    (busy),
      .expired (expired)
   );

   int n_vec = 0;
   int n_bad = 0;

   // behavioural model: who owns, how many cycles it has shown g, who is masked
   int m_owner = -1;
   int m_held  = 0;
   int m_mask  = -1;
   bit m_gap   = 1'b0;
   bit m_exp   = 1'b0;

   // observed-property trackers
   int run      = 0;
   bit prev_exp = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_step(input logic [0:N-1] rv, input logic rst);
      int others;
      if (rst) begin
         m_owner = -1; m_held = 0; m_mask = -1; m_gap = 1'b0; m_exp = 1'b0;
         return;
      end
      m_exp = 1'b0;
      if (m_owner >= 0) begin
         if (!rv[m_owner]) begin
            m_owner = -1;
         end else if (m_held == MH) begin
            m_mask  = m_owner;
            m_owner = -1;
            m_exp   = 1'b1;
            m_gap   = 1'b1;
         end else begin
            m_held++;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (rv != '0) begin
         others = 0;
         for (int i = 0; i < N; i++)
            if (rv[i] && i != m_mask) others++;
         for (int i = N - 1; i >= 0; i--)
            if (rv[i] && (others == 0 || i != m_mask)) m_owner = i;
         m_held = 1;
         m_mask = -1;
      end
   endfunction

   task automatic compare_all();
      logic [0:N-1] exp_g;
      exp_g = '0;
      if (m_owner >= 0) exp_g[m_owner] = 1'b1;
      chk("g", 32'(g), 32'(exp_g));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("expired", 32'(expired), 32'(m_exp));
      if (m_owner >= 0) chk("owner", 32'(owner), 32'(m_owner));
      chk("onehot0", 32'($onehot0(g)), 32'd1);
      chk("busy_eq_or_g", 32'(busy), 32'(|g));
      if (|g) run++; else run = 0;
      chk("run_le_max", 32'(run <= MH), 32'd1);
      chk("exp_not_consec", 32'(prev_exp && expired), 32'd0);
      prev_exp = expired;
   endtask

   task automatic step(input logic [0:N-1] rv, input logic rst);
      @(negedge clk);
      r     = rv;
      reset = rst;
      @(posedge clk);
      model_step(rv, rst);
      #1;
      compare_all();
   endtask

   initial begin
      logic [0:N-1] rv;
      r     = '0;
      reset = 1'b1;

      // reset state
      step('0, 1'b1);
      step('0, 1'b1);
      chk("rst_g", 32'(g), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_expired", 32'(expired), 32'd0);

      // priority: lower index wins
      step(8'b00100100, 1'b0);
      chk("prio_g", 32'(g), 32'(8'b00100000));
      chk("prio_owner", 32'(owner), 32'd2);
      chk("prio_busy", 32'(busy), 32'd1);
      step('0, 1'b1);

      // lone requester times out and is regranted after GAP + IDLE
      for (int k = 0; k < 12; k++) begin
         step(8'b00100000, 1'b0);
         chk("lone_busy", 32'(busy), 32'((k < 4) || (k >= 6 && k < 10)));
         chk("lone_expired", 32'(expired), 32'(k == 4 || k == 10));
      end
      step('0, 1'b1);

      // fairness: timed-out owner yields to the other requester
      for (int k = 0; k < 13; k++) begin
         step(8'b00100100, 1'b0);
         if (k == 0)  chk("fair_first", 32'(owner), 32'd2);
         if (k == 6)  chk("fair_second", 32'(owner), 32'd5);
         if (k == 12) chk("fair_third", 32'(owner), 32'd2);
      end
      step('0, 1'b1);

      // voluntary release in the 2nd owned cycle, then re-arbitration
      step(8'b00100000, 1'b0);
      step(8'b00100000, 1'b0);
      step(8'b00000100, 1'b0);
      chk("rel_g", 32'(g), 32'd0);
      chk("rel_expired", 32'(expired), 32'd0);
      step(8'b00000100, 1'b0);
      chk("rel_regrant", 32'(g), 32'(8'b00000100));
      step('0, 1'b1);

      // reset in the middle of ownership
      step(8'b00100000, 1'b0);
      step(8'b00100000, 1'b0);
      step(8'b00100000, 1'b0);
      step(8'b00100000, 1'b1);
      chk("midrst_g", 32'(g), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_owner", 32'(owner), 32'd0);
      step(8'b10000000, 1'b0);
      chk("midrst_regrant", 32'(g), 32'(8'b10000000));

      // randomized traffic: requests persist for a while so timeouts happen
      rv = '0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) == 0)
            rv = N'($urandom & $urandom & $urandom);
         step(rv, ($urandom_range(0, 199) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
